// File: rtl/c1_bus_pkg.sv
// Shared widths, command codes, FSM state and request payload for the C1 bus responder.
package c1_bus_pkg;

  localparam int unsigned C1_W  = 3;
  localparam int unsigned A_W   = 15;
  localparam int unsigned D_W   = 16;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned BA_W  = A_W + OFF_W;

  localparam logic [C1_W-1:0] CMD_NOP          = 3'd0;
  localparam logic [C1_W-1:0] CMD_READ8        = 3'd1;
  localparam logic [C1_W-1:0] CMD_READ16       = 3'd2;
  localparam logic [C1_W-1:0] CMD_READ32       = 3'd3;
  localparam logic [C1_W-1:0] CMD_INVALIDATE   = 3'd4;
  localparam logic [C1_W-1:0] CMD_WRITE8       = 3'd5;
  localparam logic [C1_W-1:0] CMD_WRITE16      = 3'd6;
  localparam logic [C1_W-1:0] CMD_WRITE32      = 3'd7;
  localparam logic [C1_W-1:0] CMD_RESPONSE     = 3'd7;

  typedef enum logic [2:0] {IDLE, ADDR2, WAIT, RESP1, RESP2} state_t;

  // Command captured over the two-cycle address phase
  typedef struct packed {
    logic [C1_W-1:0]  cmd;
    logic [A_W-1:0]   addr_hi;
    logic [OFF_W-1:0] off;
    logic [D_W-1:0]   data_lo;
    logic [D_W-1:0]   data_hi;
  } c1_req_t;

  function automatic logic is_read(input logic [C1_W-1:0] cmd);
    return (cmd == CMD_READ8) || (cmd == CMD_READ16) || (cmd == CMD_READ32);
  endfunction

  function automatic logic is_write(input logic [C1_W-1:0] cmd);
    return (cmd == CMD_WRITE8) || (cmd == CMD_WRITE16) || (cmd == CMD_WRITE32);
  endfunction

endpackage

// File: rtl/c1_bus_responder_if.sv
// C1 bus: shared C1/D1 lines resolved from responder and initiator drivers; A1 is initiator-driven.
interface c1_bus_responder_if;
  import c1_bus_pkg::*;

  wire  [C1_W-1:0] C1;
  wire  [D_W-1:0]  D1;
  logic [A_W-1:0]  A1;

  logic            c1_rsp_oe;
  logic [C1_W-1:0] c1_rsp;
  logic            d1_rsp_oe;
  logic [D_W-1:0]  d1_rsp;

  logic            c1_ini_oe;
  logic [C1_W-1:0] c1_ini;
  logic            d1_ini_oe;
  logic [D_W-1:0]  d1_ini;

  // Responder wins if both sides drive; undriven lines float
  assign C1 = c1_rsp_oe ? c1_rsp : (c1_ini_oe ? c1_ini : {C1_W{1'bz}});
  assign D1 = d1_rsp_oe ? d1_rsp : (d1_ini_oe ? d1_ini : {D_W{1'bz}});

  modport master (input C1, D1, output A1, c1_ini_oe, c1_ini, d1_ini_oe, d1_ini);
  modport slave  (input C1, D1, A1, output c1_rsp_oe, c1_rsp, d1_rsp_oe, d1_rsp);

endinterface

// File: rtl/c1_word_store.sv
// Word store: synchronous byte-enabled write, async read of word idx and idx+1 (wrapping).
module c1_word_store
  import c1_bus_pkg::*;
#(
  parameter  int unsigned MEM_WORDS = 256,
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       be_lo,
  input  logic             we_hi,
  input  logic [D_W-1:0]   wdata_lo,
  input  logic [D_W-1:0]   wdata_hi,
  output logic [D_W-1:0]   rdata_lo,
  output logic [D_W-1:0]   rdata_hi
);

  logic [D_W-1:0]   mem [MEM_WORDS];
  logic [IDX_W-1:0] idx_hi;

  assign idx_hi   = idx + IDX_W'(1);
  assign rdata_lo = mem[idx];
  assign rdata_hi = mem[idx_hi];

  always_ff @(posedge clk) begin
    if (be_lo[0]) mem[idx][7:0]  <= wdata_lo[7:0];
    if (be_lo[1]) mem[idx][15:8] <= wdata_lo[15:8];
    if (we_hi)    mem[idx_hi]    <= wdata_hi;
  end

endmodule

// File: rtl/c1_bus_responder.sv
// C1 bus memory-side responder: two-cycle address phase, fixed NOP latency, RESPONSE return.
// Define C1_RESP_TRACE_EN to print one line per accepted command and per RESPONSE cycle.
module c1_bus_responder
  import c1_bus_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 4,
  parameter int unsigned MEM_WORDS    = 256
) (
  input logic               clk,
  input logic               rst_n,
  c1_bus_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  c1_req_t         req, req_n;
  logic            c1_oe, c1_oe_n;
  logic [C1_W-1:0] c1_val, c1_val_n;
  logic            d1_oe, d1_oe_n;
  logic [D_W-1:0]  d1_val, d1_val_n;

  logic [BA_W-1:0]  baddr_c;
  logic [IDX_W-1:0] idx_c;
  logic [1:0]       be_lo_c;
  logic             we_hi_c;
  logic [D_W-1:0]   wdata_lo_c;
  logic [D_W-1:0]   rdata_lo, rdata_hi, rd_fmt_c;
  logic             wide_c;

  assign baddr_c = {req.addr_hi, req.off};
  assign wide_c  = (req.cmd == CMD_READ32) || (req.cmd == CMD_WRITE32);
  // 32-bit accesses are word-pair aligned
  assign idx_c   = IDX_W'(baddr_c[BA_W-1:1]) & ~IDX_W'(wide_c);

  c1_word_store #(.MEM_WORDS(MEM_WORDS)) u_store (
    .clk      (clk),
    .idx      (idx_c),
    .be_lo    (be_lo_c),
    .we_hi    (we_hi_c),
    .wdata_lo (wdata_lo_c),
    .wdata_hi (req.data_hi),
    .rdata_lo (rdata_lo),
    .rdata_hi (rdata_hi)
  );

  // Byte-lane select for READ8, zero-extended
  always_comb begin
    rd_fmt_c = rdata_lo;
    if (req.cmd == CMD_READ8)
      rd_fmt_c = baddr_c[0] ? {8'h00, rdata_lo[15:8]} : {8'h00, rdata_lo[7:0]};
  end

  // Writes commit once, on the first WAIT edge
  always_comb begin
    be_lo_c    = 2'b00;
    we_hi_c    = 1'b0;
    wdata_lo_c = req.data_lo;
    if ((state == WAIT) && (cnt == CNT_W'(RESP_LATENCY))) begin
      case (req.cmd)
        CMD_WRITE8: begin
          be_lo_c    = baddr_c[0] ? 2'b10 : 2'b01;
          wdata_lo_c = {2{req.data_lo[7:0]}};
        end
        CMD_WRITE16: be_lo_c = 2'b11;
        CMD_WRITE32: begin
          be_lo_c = 2'b11;
          we_hi_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    req_n    = req;
    c1_oe_n  = 1'b0;
    c1_val_n = CMD_NOP;
    d1_oe_n  = 1'b0;
    d1_val_n = '0;
    case (state)
      IDLE: begin
        if (bus.C1 != CMD_NOP) begin
          req_n         = '0;
          req_n.cmd     = bus.C1;
          req_n.addr_hi = bus.A1;
          req_n.data_lo = bus.D1;
          state_n       = ADDR2;
        end
      end
      ADDR2: begin
        req_n.off = bus.A1[OFF_W-1:0];
        if (req.cmd == CMD_WRITE32) req_n.data_hi = bus.D1;
        cnt_n   = CNT_W'(RESP_LATENCY);
        c1_oe_n = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n   = cnt - CNT_W'(1);
        c1_oe_n = 1'b1;
        if (cnt_n == '0) begin
          c1_val_n = CMD_RESPONSE;
          d1_oe_n  = is_read(req.cmd);
          d1_val_n = rd_fmt_c;
          state_n  = RESP1;
        end
      end
      RESP1: begin
        if (req.cmd == CMD_READ32) begin
          c1_oe_n  = 1'b1;
          c1_val_n = CMD_RESPONSE;
          d1_oe_n  = 1'b1;
          d1_val_n = rdata_hi;
          state_n  = RESP2;
        end else begin
          state_n = IDLE;
        end
      end
      RESP2:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      req    <= '0;
      c1_oe  <= 1'b0;
      c1_val <= CMD_NOP;
      d1_oe  <= 1'b0;
      d1_val <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      req    <= req_n;
      c1_oe  <= c1_oe_n;
      c1_val <= c1_val_n;
      d1_oe  <= d1_oe_n;
      d1_val <= d1_val_n;
    end
  end

  assign bus.c1_rsp_oe = c1_oe;
  assign bus.c1_rsp    = c1_val;
  assign bus.d1_rsp_oe = d1_oe;
  assign bus.d1_rsp    = d1_val;

`ifdef C1_RESP_TRACE_EN
  function automatic string cmd_name(input logic [C1_W-1:0] cmd);
    case (cmd)
      CMD_READ8:      return "READ8";
      CMD_READ16:     return "READ16";
      CMD_READ32:     return "READ32";
      CMD_INVALIDATE: return "INVALIDATE_LINE";
      CMD_WRITE8:     return "WRITE8";
      CMD_WRITE16:    return "WRITE16";
      CMD_WRITE32:    return "WRITE32";
      default:        return "NOP";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n && (state == ADDR2))
      $display("%0t c1_resp accept %s addr=0x%05h data=0x%04h", $time, cmd_name(req.cmd),
               {req.addr_hi, bus.A1[OFF_W-1:0]}, req.data_lo);
    if (rst_n && c1_oe && (c1_val == CMD_RESPONSE))
      $display("%0t c1_resp RESPONSE data=0x%04h driven=%0d", $time, d1_val, d1_oe);
  end
`endif

endmodule

// File: tb/tb_c1_bus_responder.sv
// Directed bench for c1_bus_responder: bus transactions with hand-computed responses.
module tb_c1_bus_responder;
  import c1_bus_pkg::*;

  localparam int unsigned L = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  c1_bus_responder_if bus();

  c1_bus_responder #(.RESP_LATENCY(L), .MEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the two-cycle address phase, then releases the bus at the start of the first WAIT cycle
  task automatic issue(input logic [2:0] cmd, input logic [18:0] baddr,
                       input logic [15:0] w0, input logic [15:0] w1);
    @(negedge clk);
    bus.c1_ini_oe = 1'b1;
    bus.c1_ini    = cmd;
    bus.A1        = baddr[18:4];
    bus.d1_ini_oe = cmd[2];
    bus.d1_ini    = w0;
    @(negedge clk);
    bus.A1     = {11'd0, baddr[3:0]};
    bus.d1_ini = w1;
    @(negedge clk);
    bus.c1_ini_oe = 1'b0;
    bus.d1_ini_oe = 1'b0;
    bus.A1        = '0;
  endtask

  // Expects L NOP cycles, RESPONSE (two for wide reads), then a released bus
  task automatic expect_resp(input string tag, input logic rd, input logic two,
                             input logic [15:0] e0, input logic [15:0] e1, input logic inject);
    for (int i = 0; i < int'(L); i++) begin
      if (inject && i == 0) begin
        bus.c1_ini_oe = 1'b1;
        bus.c1_ini    = CMD_READ16;
        bus.A1        = 15'h0001;
      end
      if (inject && i == 2) begin
        bus.c1_ini_oe = 1'b0;
        bus.A1        = '0;
      end
      #1;
      check({tag, "_nop"}, 32'({bus.c1_rsp_oe, bus.C1, bus.d1_rsp_oe}), 32'({1'b1, CMD_NOP, 1'b0}));
      @(negedge clk);
    end
    #1;
    check({tag, "_rsp"}, 32'({bus.c1_rsp_oe, bus.C1, bus.d1_rsp_oe}), 32'({1'b1, CMD_RESPONSE, rd}));
    if (rd) check({tag, "_d0"}, 32'(bus.D1), 32'(e0));
    if (two) begin
      @(negedge clk);
      #1;
      check({tag, "_rsp2"}, 32'({bus.c1_rsp_oe, bus.C1, bus.d1_rsp_oe}), 32'({1'b1, CMD_RESPONSE, 1'b1}));
      check({tag, "_d1"}, 32'(bus.D1), 32'(e1));
    end
    @(negedge clk);
    #1;
    check({tag, "_rel"}, 32'({bus.c1_rsp_oe, bus.d1_rsp_oe}), 32'(0));
  endtask

  initial begin
    bus.c1_ini_oe = 1'b0;
    bus.c1_ini    = CMD_NOP;
    bus.d1_ini_oe = 1'b0;
    bus.d1_ini    = '0;
    bus.A1        = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_idle", 32'({bus.c1_rsp_oe, bus.d1_rsp_oe}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue(CMD_WRITE16, 19'h00010, 16'hBEEF, 16'h0000);
    expect_resp("wr16_10", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    issue(CMD_READ16, 19'h00010, 16'h0, 16'h0);
    expect_resp("rd16_10", 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b0);

    issue(CMD_WRITE16, 19'h00012, 16'h12EF, 16'h0000);
    expect_resp("wr16_12", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    issue(CMD_WRITE8, 19'h00013, 16'h33A5, 16'h0000);
    expect_resp("wr8_13", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    issue(CMD_READ8, 19'h00013, 16'h0, 16'h0);
    expect_resp("rd8_13", 1'b1, 1'b0, 16'h00A5, 16'h0, 1'b0);
    issue(CMD_READ16, 19'h00012, 16'h0, 16'h0);
    expect_resp("rd16_12", 1'b1, 1'b0, 16'hA5EF, 16'h0, 1'b0);
    issue(CMD_READ8, 19'h00010, 16'h0, 16'h0);
    expect_resp("rd8_10", 1'b1, 1'b0, 16'h00EF, 16'h0, 1'b0);
    issue(CMD_READ8, 19'h00011, 16'h0, 16'h0);
    expect_resp("rd8_11", 1'b1, 1'b0, 16'h00BE, 16'h0, 1'b0);

    issue(CMD_WRITE32, 19'h00020, 16'h1234, 16'h5678);
    expect_resp("wr32_20", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    issue(CMD_READ32, 19'h00022, 16'h0, 16'h0);
    expect_resp("rd32_22", 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
    issue(CMD_READ16, 19'h00022, 16'h0, 16'h0);
    expect_resp("rd16_22", 1'b1, 1'b0, 16'h5678, 16'h0, 1'b0);
    // 0x210 aliases word 8 in a 256-word store
    issue(CMD_READ16, 19'h00210, 16'h0, 16'h0);
    expect_resp("rd16_alias", 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b0);

    issue(CMD_INVALIDATE, 19'h00010, 16'hDEAD, 16'h0000);
    expect_resp("inval", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    issue(CMD_READ16, 19'h00010, 16'h0, 16'h0);
    expect_resp("rd16_postinv", 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b0);

    issue(CMD_READ16, 19'h00010, 16'h0, 16'h0);
    expect_resp("rd16_inject", 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b1);
    for (int i = 0; i < int'(L) + 4; i++) begin
      @(negedge clk);
      #1;
      check("quiet_after_inject", 32'({bus.c1_rsp_oe, bus.d1_rsp_oe}), 32'(0));
    end

    issue(CMD_READ16, 19'h00010, 16'h0, 16'h0);
    #1;
    check("pre_rst_wait", 32'({bus.c1_rsp_oe, bus.C1}), 32'({1'b1, CMD_NOP}));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'({bus.c1_rsp_oe, bus.d1_rsp_oe}), 32'(0));
    @(negedge clk);
    #1;
    check("rst_hold", 32'({bus.c1_rsp_oe, bus.d1_rsp_oe}), 32'(0));
    rst_n = 1'b1;
    issue(CMD_READ8, 19'h00013, 16'h0, 16'h0);
    expect_resp("rd8_postrst", 1'b1, 1'b0, 16'h00A5, 16'h0, 1'b0);
    issue(CMD_READ16, 19'h00020, 16'h0, 16'h0);
    expect_resp("rd16_postrst", 1'b1, 1'b0, 16'h1234, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
